// File: rtl/i3c_xfer_arbiter.sv
// Round-robin arbiter/sequencer sharing one I3C transfer engine among NUM_REQ
// requesters; holds the grant until completion and aborts hung transfers.
module i3c_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*7-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]       req_rnw,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       cmp_valid,
  output logic [1:0]               cmp_status,
  output logic                     eng_valid,
  input  logic                     eng_ready,
  output logic [6:0]               eng_addr,
  output logic                     eng_rnw,
  output logic [LEN_W-1:0]         eng_len,
  input  logic                     eng_done,
  input  logic                     eng_nack,
  output logic                     eng_abort,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  logic [1:0]         state_q,  state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [6:0]         addr_q,   addr_d;
  logic               rnw_q,    rnw_d;
  logic [LEN_W-1:0]   len_q,    len_d;
  logic [TMR_W-1:0]   timer_q,  timer_d;
  logic [1:0]         status_q, status_d;
  logic [NUM_REQ-1:0] ack_q,    ack_d;
  logic               abort_q,  abort_d;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  int unsigned        cand;
  logic [IDX_W-1:0]   cand_idx;
  logic [6:0]         sel_addr;
  logic               sel_rnw;
  logic [LEN_W-1:0]   sel_len;
  logic [NUM_REQ-1:0] win_1h;
  logic               wd_expire;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!arb_found && req_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_rnw  = 1'b0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr = req_addr[7*i +: 7];
        sel_rnw  = req_rnw[i];
        sel_len  = req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  assign win_1h    = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q;
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    rnw_d    = rnw_q;
    len_d    = len_q;
    timer_d  = timer_q;
    status_d = status_q;
    ack_d    = '0;
    abort_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          winner_d = arb_idx;
          addr_d   = sel_addr;
          rnw_d    = sel_rnw;
          len_d    = sel_len;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_ready) begin
          ack_d   = win_1h;
          timer_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        timer_d = timer_q + 1'b1;
        // A completion in the expiry cycle takes precedence over the abort.
        if (eng_done) begin
          status_d = eng_nack ? ST_NACK : ST_OK;
          state_d  = S_DONE;
        end else if (wd_expire) begin
          abort_d  = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      len_q    <= '0;
      timer_q  <= '0;
      status_q <= '0;
      ack_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      len_q    <= len_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      ack_q    <= ack_d;
      abort_q  <= abort_d;
    end
  end

  assign req_ack    = ack_q;
  assign cmp_valid  = (state_q == S_DONE) ? win_1h : '0;
  assign cmp_status = status_q;
  assign eng_valid  = (state_q == S_ISSUE);
  assign eng_addr   = addr_q;
  assign eng_rnw    = rnw_q;
  assign eng_len    = len_q;
  assign eng_abort  = abort_q;
  assign busy       = (state_q != S_IDLE);

endmodule
